id_ex_reg: RTL and testbench

- Pipeline register between the decode stage and the execute stage.
- Captures the decoded instruction bundle each cycle: pc, instruction, operand data, rd address, immediate and the 16-bit control bundle.
- Presents the captured bundle to execute as registered outputs.
- Freezes on hold requests from execute, and squashes wrong-path instructions with NOP bubbles after a jump or taken branch.

---
 rtl/id_ex_reg.sv | 165 ++++++++++++++++
 tb/tb_id_ex_reg.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with hold, jump flush bubbles and optional
// operand forwarding (enable with `define ID_EX_FWD_EN).
module id_ex_reg #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_pc_addr,
    input  logic [31:0] i_inst_data,
    input  logic [4:0]  i_reg1_addr,
    input  logic [4:0]  i_reg2_addr,
    input  logic [31:0] i_reg1_data,
    input  logic [31:0] i_reg2_data,
    input  logic [4:0]  i_regd_addr,
    input  logic [31:0] i_imm_data,
    input  logic [15:0] i_ctrl,
    input  logic        i_hold_flag,
    input  logic        i_jump_flag,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_valid,
    output logic [31:0] o_pc_addr,
    output logic [31:0] o_inst_data,
    output logic [31:0] o_reg1_data,
    output logic [31:0] o_reg2_data,
    output logic [4:0]  o_regd_addr,
    output logic [31:0] o_imm_data,
    output logic [15:0] o_ctrl,
    output logic        o_flushing
);

    localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 1);

    // Asserts asynchronously, releases two clocks after i_reset rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [31:0] reg1_sel;
    logic [31:0] reg2_sel;

`ifdef ID_EX_FWD_EN
    always_comb begin
        reg1_sel = i_reg1_data;
        reg2_sel = i_reg2_data;
        if (i_wb_we && (i_wb_addr != 5'd0) && (i_wb_addr == i_reg1_addr)) begin
            reg1_sel = i_wb_data;
        end
        if (i_wb_we && (i_wb_addr != 5'd0) && (i_wb_addr == i_reg2_addr)) begin
            reg2_sel = i_wb_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{i_reg1_addr, i_reg2_addr, i_wb_we, i_wb_addr, i_wb_data};
    assign reg1_sel   = i_reg1_data;
    assign reg2_sel   = i_reg2_data;
`endif

    logic        valid_d, valid_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] inst_d, inst_q;
    logic [31:0] reg1_d, reg1_q;
    logic [31:0] reg2_d, reg2_q;
    logic [4:0]  regd_d, regd_q;
    logic [31:0] imm_d, imm_q;
    logic [15:0] ctrl_d, ctrl_q;
    logic [2:0]  cnt_d, cnt_q;
    logic        flushing_q;
    logic        bubble;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        regd_d  = regd_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;

        if (i_jump_flag) begin
            bubble = 1'b1;
            cnt_d  = FlushReload;
        end else if (cnt_q != 3'd0) begin
            bubble = 1'b1;
            cnt_d  = cnt_q - 3'd1;
        end else if (i_hold_flag) begin
            bubble = 1'b0;
        end else if (!i_valid) begin
            bubble = 1'b1;
        end else begin
            valid_d = 1'b1;
            pc_d    = i_pc_addr;
            inst_d  = i_inst_data;
            reg1_d  = reg1_sel;
            reg2_d  = reg2_sel;
            regd_d  = i_regd_addr;
            imm_d   = i_imm_data;
            ctrl_d  = i_ctrl;
        end

        // A bubble keeps pc so execute still sees the last fetched address.
        if (bubble) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            reg1_d  = 32'd0;
            reg2_d  = 32'd0;
            regd_d  = 5'd0;
            imm_d   = 32'd0;
            ctrl_d  = 16'h0000;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= 32'd0;
            inst_q     <= NOP_INST;
            reg1_q     <= 32'd0;
            reg2_q     <= 32'd0;
            regd_q     <= 5'd0;
            imm_q      <= 32'd0;
            ctrl_q     <= 16'h0000;
            cnt_q      <= 3'd0;
            flushing_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
            regd_q     <= regd_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
            flushing_q <= (cnt_d != 3'd0);
        end
    end

    assign o_valid     = valid_q;
    assign o_pc_addr   = pc_q;
    assign o_inst_data = inst_q;
    assign o_reg1_data = reg1_q;
    assign o_reg2_data = reg2_q;
    assign o_regd_addr = regd_q;
    assign o_imm_data  = imm_q;
    assign o_ctrl      = ctrl_q;
    assign o_flushing  = flushing_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed and random stimulus for id_ex_reg; expected bundles come from a small
// reference model and are queued per edge, then popped and compared.
module tb_id_ex_reg;

    localparam int unsigned FL  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic        fl;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_pc_addr = '0;
    logic [31:0] i_inst_data = '0;
    logic [4:0]  i_reg1_addr = '0;
    logic [4:0]  i_reg2_addr = '0;
    logic [31:0] i_reg1_data = '0;
    logic [31:0] i_reg2_data = '0;
    logic [4:0]  i_regd_addr = '0;
    logic [31:0] i_imm_data = '0;
    logic [15:0] i_ctrl = '0;
    logic        i_hold_flag = 1'b0;
    logic        i_jump_flag = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [4:0]  i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic        o_valid;
    logic [31:0] o_pc_addr;
    logic [31:0] o_inst_data;
    logic [31:0] o_reg1_data;
    logic [31:0] o_reg2_data;
    logic [4:0]  o_regd_addr;
    logic [31:0] o_imm_data;
    logic [15:0] o_ctrl;
    logic        o_flushing;

    id_ex_reg #(
        .FLUSH_CYCLES(FL),
        .NOP_INST    (NOP)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_pc_addr  (i_pc_addr),
        .i_inst_data(i_inst_data),
        .i_reg1_addr(i_reg1_addr),
        .i_reg2_addr(i_reg2_addr),
        .i_reg1_data(i_reg1_data),
        .i_reg2_data(i_reg2_data),
        .i_regd_addr(i_regd_addr),
        .i_imm_data (i_imm_data),
        .i_ctrl     (i_ctrl),
        .i_hold_flag(i_hold_flag),
        .i_jump_flag(i_jump_flag),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_valid    (o_valid),
        .o_pc_addr  (o_pc_addr),
        .o_inst_data(o_inst_data),
        .o_reg1_data(o_reg1_data),
        .o_reg2_data(o_reg2_data),
        .o_regd_addr(o_regd_addr),
        .o_imm_data (o_imm_data),
        .o_ctrl     (o_ctrl),
        .o_flushing (o_flushing)
    );

    always #5 i_clk = ~i_clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t m;
    int   mcnt;
    exp_t rst_exp;

    task automatic check(input exp_t e, input string tag);
        exp_t got;
        got = {o_valid, o_pc_addr, o_inst_data, o_reg1_data, o_reg2_data, o_regd_addr,
               o_imm_data, o_ctrl, o_flushing};
        n_cmp++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, e);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
`ifdef ID_EX_FWD_EN
        if (i_wb_we && i_wb_addr != 5'd0 && i_wb_addr == a) return i_wb_data;
`endif
        return (a == 5'd31) ? d : d;
    endfunction

    task automatic rand_in();
        i_valid     = 1'($urandom_range(0, 3) != 0);
        i_pc_addr   = $urandom;
        i_inst_data = $urandom;
        i_reg1_addr = 5'($urandom);
        i_reg2_addr = 5'($urandom);
        i_reg1_data = $urandom;
        i_reg2_data = $urandom;
        i_regd_addr = 5'($urandom);
        i_imm_data  = $urandom;
        i_ctrl      = 16'($urandom);
        i_wb_we     = 1'($urandom);
        i_wb_addr   = 5'($urandom_range(0, 3));
        i_wb_data   = $urandom;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [15:0] ctrl);
        i_valid = 1'b1;
        i_pc_addr = pc;
        i_inst_data = inst;
        i_ctrl = ctrl;
        i_reg1_data = pc ^ 32'h1111;
        i_reg2_data = pc ^ 32'h2222;
        i_regd_addr = pc[6:2];
        i_imm_data = pc + 32'h40;
    endtask

    task automatic step(input string tag);
        exp_t n;
        int   c;
        n = m;
        c = mcnt;
        if (i_jump_flag || c != 0 || (!i_hold_flag && !i_valid)) begin
            c = i_jump_flag ? int'(FL) - 1 : (c != 0 ? c - 1 : 0);
            n.v = 1'b0; n.inst = NOP; n.r1 = '0; n.r2 = '0;
            n.rd = '0; n.imm = '0; n.ctrl = '0;
        end else if (!i_hold_flag) begin
            n.v = 1'b1; n.pc = i_pc_addr; n.inst = i_inst_data;
            n.r1 = fwd(i_reg1_addr, i_reg1_data);
            n.r2 = fwd(i_reg2_addr, i_reg2_data);
            n.rd = i_regd_addr; n.imm = i_imm_data; n.ctrl = i_ctrl;
        end
        n.fl = (c != 0);
        m = n;
        mcnt = c;
        q.push_back(n);
        @(posedge i_clk);
        #1;
        check(q.pop_front(), tag);
    endtask

    task automatic reset_step(input string tag);
        q.push_back(rst_exp);
        m = rst_exp;
        mcnt = 0;
        @(posedge i_clk);
        #1;
        check(q.pop_front(), tag);
    endtask

    initial begin
        rst_exp = '{v: 1'b0, pc: '0, inst: NOP, r1: '0, r2: '0, rd: '0, imm: '0,
                    ctrl: '0, fl: 1'b0};
        m = rst_exp;
        mcnt = 0;

        // Reset held with random inputs, including jumps.
        for (int i = 0; i < 4; i++) begin
            rand_in();
            i_jump_flag = 1'($urandom);
            i_hold_flag = 1'($urandom);
            reset_step("reset_hold");
        end
        rand_in();
        i_reset = 1'b1;
        reset_step("reset_sync1");
        reset_step("reset_sync2");
        i_jump_flag = 1'b0;
        i_hold_flag = 1'b0;
        i_valid = 1'b0;
        i_wb_we = 1'b0;
        step("idle_bubble");

        drive(32'h100, 32'h0050_0093, 16'h8100);
        step("capture_100");
        drive(32'h104, 32'h0000_0113, 16'h0008);
        step("capture_104");

        i_hold_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h200 + 32'(i * 4), $urandom, 16'($urandom));
            step("hold");
        end
        i_hold_flag = 1'b0;
        drive(32'h108, 32'h0020_0193, 16'h8000);
        step("hold_release");

        i_jump_flag = 1'b1;
        drive(32'h10c, 32'h1234_5678, 16'hffff);
        step("jump_bubble1");
        i_jump_flag = 1'b0;
        drive(32'h110, 32'h2234_5678, 16'h8001);
        step("jump_bubble2");
        drive(32'h300, 32'h3234_5678, 16'h8002);
        step("after_flush");

        // Jump beats hold, re-jump restarts the counter, hold does not stall it.
        i_hold_flag = 1'b1;
        i_jump_flag = 1'b1;
        step("jump_over_hold");
        i_hold_flag = 1'b0;
        step("rejump");
        i_jump_flag = 1'b0;
        i_hold_flag = 1'b1;
        step("flush_during_hold");
        step("hold_after_flush");
        i_hold_flag = 1'b0;
        drive(32'h400, 32'h0000_0033, 16'h8000);
        step("capture_400");
        i_valid = 1'b0;
        step("invalid_bubble");

        // Forwarding: rs1 matches a live writeback, then writeback to x0.
        drive(32'h500, 32'h0000_00b3, 16'h8000);
        i_reg1_addr = 5'd5;
        i_reg1_data = 32'h1;
        i_reg2_addr = 5'd6;
        i_wb_we = 1'b1;
        i_wb_addr = 5'd5;
        i_wb_data = 32'h0000_dead;
        step("fwd_rs1");
        i_wb_addr = 5'd0;
        i_reg1_addr = 5'd0;
        step("fwd_x0");
        i_wb_addr = 5'd6;
        step("fwd_rs2");
        i_wb_we = 1'b0;

        for (int i = 0; i < 60; i++) begin
            rand_in();
            i_jump_flag = 1'($urandom_range(0, 7) == 0);
            i_hold_flag = 1'($urandom_range(0, 3) == 0);
            step("random");
        end

        // Reset in the middle of a flush clears the counter without a clock edge.
        i_hold_flag = 1'b0;
        i_jump_flag = 1'b1;
        step("pre_reset_jump");
        i_jump_flag = 1'b0;
        #2;
        i_reset = 1'b0;
        #1;
        m = rst_exp;
        mcnt = 0;
        check(rst_exp, "async_reset_mid_flush");
        reset_step("reset_again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
